// File: rtl/fused_bram_load_sequencer.sv
// Fused-layer tile loader: streams IFM, layer-1 weights and layer-2 weights
// from the 128-bit global BRAM into the local fused banks, one word per cycle.
// Read addresses are issued in stage p0; the matching bank write enable and
// local address follow one cycle later to line up with global read data.
module fused_bram_load_sequencer #(
  parameter int ADDR_W       = 32,
  parameter int NUM_W1_BANKS = 16,
  parameter int NUM_W2_BANKS = 4,
  parameter int WORD_BYTES   = 16
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     start,
  input  logic [ADDR_W-1:0]                        base_addr_IFM,
  input  logic [ADDR_W-1:0]                        size_IFM,
  input  logic [ADDR_W-1:0]                        base_addr_Weight_layer_1,
  input  logic [ADDR_W-1:0]                        size_Weight_layer_1,
  input  logic [ADDR_W-1:0]                        base_addr_Weight_layer_2,
  input  logic [ADDR_W-1:0]                        size_Weight_layer_2,
  output logic [ADDR_W-1:0]                        rd_addr_global,
  output logic [ADDR_W-1:0]                        wr_addr_fused,
  output logic [NUM_W1_BANKS+NUM_W2_BANKS:0]       we_fused,
  output logic                                     busy,
  output logic                                     ready,
  output logic                                     done
);

  localparam int NB     = NUM_W1_BANKS + NUM_W2_BANKS + 1;
  localparam int WSH    = $clog2(WORD_BYTES);
  localparam int W1SH   = WSH + $clog2(NUM_W1_BANKS);
  localparam int W2SH   = WSH + $clog2(NUM_W2_BANKS);
  localparam int BANK_W = $clog2(NUM_W1_BANKS) + 1;

  typedef enum logic [2:0] {IDLE, IFM, W1, W2, DRAIN, DONE} state_t;

  typedef struct packed {
    state_t            st;
    logic [ADDR_W-1:0] addr;
    logic [NB-1:0]     we;
  } entry_t;

  state_t            state;
  logic [ADDR_W-1:0] ifm_w, w1_pb, w2_pb;
  logic [ADDR_W-1:0] base_w1, base_w2;
  logic [ADDR_W-1:0] word_idx;
  logic [BANK_W-1:0] bank_idx;
  logic [NB-1:0]     we_p0;
  logic [ADDR_W-1:0] wr_addr_p0;

  logic [ADDR_W-1:0] seg_len;
  logic              last_word, last_bank;
  logic [1:0]        next_from;
  entry_t            start_ent, seg_ent;

  // First non-empty segment at or after 'from' (0=IFM, 1=W1, 2=W2, 3=none);
  // an all-empty remainder goes straight to DRAIN with the read address held.
  function automatic entry_t pick(input logic [1:0] from,
                                  input logic [ADDR_W-1:0] n0, n1, n2,
                                  input logic [ADDR_W-1:0] a0, a1, a2,
                                  input logic [ADDR_W-1:0] hold);
    entry_t e;
    e.st   = DRAIN;
    e.addr = hold;
    e.we   = '0;
    if (from == 2'd0 && n0 != '0) begin
      e.st = IFM; e.addr = a0; e.we = NB'(1) << (NB - 1);
    end else if (from <= 2'd1 && n1 != '0) begin
      e.st = W1;  e.addr = a1; e.we = NB'(1);
    end else if (from <= 2'd2 && n2 != '0) begin
      e.st = W2;  e.addr = a2; e.we = NB'(1) << NUM_W1_BANKS;
    end
    return e;
  endfunction

  // Per-bank length of the active segment and where the stream goes next.
  always_comb begin
    seg_len   = ifm_w;
    last_bank = 1'b1;
    next_from = 2'd1;
    case (state)
      W1: begin
        seg_len   = w1_pb;
        last_bank = (bank_idx == BANK_W'(NUM_W1_BANKS - 1));
        next_from = 2'd2;
      end
      W2: begin
        seg_len   = w2_pb;
        last_bank = (bank_idx == BANK_W'(NUM_W2_BANKS - 1));
        next_from = 2'd3;
      end
      default: ;
    endcase
    last_word = (word_idx == seg_len - ADDR_W'(1));
    start_ent = pick(2'd0, size_IFM >> WSH, size_Weight_layer_1 >> W1SH,
                     size_Weight_layer_2 >> W2SH, base_addr_IFM,
                     base_addr_Weight_layer_1, base_addr_Weight_layer_2,
                     rd_addr_global);
    seg_ent   = pick(next_from, ifm_w, w1_pb, w2_pb, base_addr_IFM,
                     base_w1, base_w2, rd_addr_global);
  end

  // Sequencer FSM: read issue in p0, write controls registered one cycle later.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      rd_addr_global <= '0;
      wr_addr_fused  <= '0;
      we_fused       <= '0;
      we_p0          <= '0;
      wr_addr_p0     <= '0;
      word_idx       <= '0;
      bank_idx       <= '0;
      busy           <= 1'b0;
      ready          <= 1'b1;
      done           <= 1'b0;
    end else begin
      // p0 -> p1: write side trails the read issue by the BRAM latency
      we_fused      <= we_p0;
      wr_addr_fused <= wr_addr_p0;
      done          <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ifm_w          <= size_IFM >> WSH;
            w1_pb          <= size_Weight_layer_1 >> W1SH;
            w2_pb          <= size_Weight_layer_2 >> W2SH;
            base_w1        <= base_addr_Weight_layer_1;
            base_w2        <= base_addr_Weight_layer_2;
            state          <= start_ent.st;
            rd_addr_global <= start_ent.addr;
            we_p0          <= start_ent.we;
            wr_addr_p0     <= '0;
            word_idx       <= '0;
            bank_idx       <= '0;
            busy           <= 1'b1;
            ready          <= 1'b0;
          end
        end
        IFM, W1, W2: begin
          rd_addr_global <= rd_addr_global + ADDR_W'(WORD_BYTES);
          if (!last_word) begin
            word_idx   <= word_idx + ADDR_W'(1);
            wr_addr_p0 <= wr_addr_p0 + ADDR_W'(WORD_BYTES);
          end else if (!last_bank) begin
            word_idx   <= '0;
            bank_idx   <= bank_idx + BANK_W'(1);
            wr_addr_p0 <= '0;
            we_p0      <= we_p0 << 1;
          end else begin
            state          <= seg_ent.st;
            rd_addr_global <= seg_ent.addr;
            we_p0          <= seg_ent.we;
            wr_addr_p0     <= '0;
            word_idx       <= '0;
            bank_idx       <= '0;
          end
        end
        DRAIN: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fused_bram_load_sequencer.sv
// Directed bench for the fused BRAM load sequencer: a list-based model of the
// expected read/write stream checked every cycle, plus literal spot checks.
module tb_fused_bram_load_sequencer;
  localparam int NB = 21;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] b0 = '0, s0 = '0, b1 = '0, s1 = '0, b2 = '0, s2 = '0;
  logic [31:0] rd_addr_global, wr_addr_fused;
  logic [NB-1:0] we_fused;
  logic        busy, ready, done;

  fused_bram_load_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .base_addr_IFM(b0), .size_IFM(s0),
    .base_addr_Weight_layer_1(b1), .size_Weight_layer_1(s1),
    .base_addr_Weight_layer_2(b2), .size_Weight_layer_2(s2),
    .rd_addr_global(rd_addr_global), .wr_addr_fused(wr_addr_fused),
    .we_fused(we_fused), .busy(busy), .ready(ready), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int done_seen = 0, we_seen = 0;
  bit cmp_on = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: on an accepted start, list every word as (read addr, bank, local addr).
  logic [31:0] q_rd[$], q_wr[$];
  int          q_bk[$];
  int          n_tot = 0, t = 0;
  bit          act = 0;

  always @(posedge clk) begin
    if (!reset_n) act = 0;
    else if (!act) begin
      if (start) begin
        q_rd.delete(); q_wr.delete(); q_bk.delete();
        for (int i = 0; i < int'(s0 / 16); i++) begin
          q_rd.push_back(b0 + 32'(16 * i)); q_wr.push_back(32'(16 * i)); q_bk.push_back(NB - 1);
        end
        for (int k = 0; k < 16; k++)
          for (int j = 0; j < int'(s1 / 256); j++) begin
            q_rd.push_back(b1 + 32'(16 * (k * int'(s1 / 256) + j)));
            q_wr.push_back(32'(16 * j)); q_bk.push_back(k);
          end
        for (int k = 0; k < 4; k++)
          for (int j = 0; j < int'(s2 / 64); j++) begin
            q_rd.push_back(b2 + 32'(16 * (k * int'(s2 / 64) + j)));
            q_wr.push_back(32'(16 * j)); q_bk.push_back(16 + k);
          end
        n_tot = q_rd.size();
        t = 1;
        act = 1;
      end
    end else begin
      t++;
      if (t > n_tot + 2) act = 0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      if (done === 1'b1) done_seen++;
      if (we_fused !== '0) we_seen++;
      if (act) begin
        if (t <= n_tot) chk("rd_addr", rd_addr_global, q_rd[t-1]);
        if (t >= 2 && t <= n_tot + 1) begin
          chk("we_fused", 32'(we_fused), 32'(1) << q_bk[t-2]);
          chk("wr_addr", wr_addr_fused, q_wr[t-2]);
        end else chk("we_quiet", 32'(we_fused), 32'd0);
        chk("done", 32'(done), 32'(t == n_tot + 2));
        chk("busy", 32'(busy), 32'd1);
        chk("ready", 32'(ready), 32'd0);
      end else begin
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ready", 32'(ready), 32'd1);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_we", 32'(we_fused), 32'd0);
      end
    end
  end

  int cyc = 0;

  task automatic cfg(input logic [31:0] a0, z0, a1, z1, a2, z2);
    b0 = a0; s0 = z0; b1 = a1; s1 = z1; b2 = a2; s2 = z2;
  endtask

  task automatic go();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic step_to(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  int d_snap, w_snap;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp_on = 1;
    chk("rst_rd", rd_addr_global, 32'd0);
    chk("rst_wr", wr_addr_fused, 32'd0);
    chk("rst_we", 32'(we_fused), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // IFM only
    cfg(32'h100, 64, 0, 0, 0, 0);
    d_snap = done_seen;
    go();
    chk("ifm_rd_c1", rd_addr_global, 32'h100);
    step_to(2); chk("ifm_we_c2", 32'(we_fused), 32'h10_0000); chk("ifm_wr_c2", wr_addr_fused, 0);
    step_to(4); chk("ifm_rd_c4", rd_addr_global, 32'h130);
    step_to(5); chk("ifm_wr_c5", wr_addr_fused, 48); chk("ifm_done_c5", 32'(done), 0);
    step_to(6); chk("ifm_done_c6", 32'(done), 1);
    step_to(7); chk("ifm_ready_c7", 32'(ready), 1);
    chk("ifm_done_count", 32'(done_seen - d_snap), 1);

    // Full load, N = 44
    cfg(32'h0, 64, 32'h1000, 512, 32'h2000, 128);
    go();
    step_to(5);  chk("full_rd_c5", rd_addr_global, 32'h1000);
    step_to(6);  chk("full_we_c6", 32'(we_fused), 1); chk("full_wr_c6", wr_addr_fused, 0);
    step_to(7);  chk("full_we_c7", 32'(we_fused), 1); chk("full_wr_c7", wr_addr_fused, 16);
                 chk("full_rd_c7", rd_addr_global, 32'h1020);
    step_to(8);  chk("full_we_c8", 32'(we_fused), 2); chk("full_wr_c8", wr_addr_fused, 0);
    step_to(37); chk("full_rd_c37", rd_addr_global, 32'h2000);
    step_to(38); chk("full_we_c38", 32'(we_fused), 32'h1_0000);
    step_to(45); chk("full_done_c45", 32'(done), 0);
    step_to(46); chk("full_done_c46", 32'(done), 1);
    step_to(47); chk("full_ready_c47", 32'(ready), 1);

    // Skip W1 (too small for one word per bank), truncate IFM to one word
    cfg(32'h40, 20, 32'h5000, 200, 0, 0);
    w_snap = we_seen;
    go();
    chk("skip_rd_c1", rd_addr_global, 32'h40);
    step_to(2); chk("skip_we_c2", 32'(we_fused), 32'h10_0000);
    step_to(3); chk("skip_done_c3", 32'(done), 1);
    step_to(4); chk("skip_we_count", 32'(we_seen - w_snap), 1);

    // Everything empty: straight to drain
    cfg(32'h80, 0, 32'h90, 0, 32'hA0, 15);
    w_snap = we_seen;
    go();
    step_to(2); chk("zero_done_c2", 32'(done), 1);
    step_to(3); chk("zero_ready_c3", 32'(ready), 1);
    chk("zero_we_count", 32'(we_seen - w_snap), 0);

    // Start while busy plus input change mid-load
    cfg(32'h0, 64, 32'h1000, 512, 32'h2000, 128);
    d_snap = done_seen;
    go();
    step_to(10); start = 1'b1; b0 = 32'hDEAD_0000;
    step_to(11); start = 1'b0;
    chk("busy_rd_c11", rd_addr_global, 32'h1060);
    step_to(46); chk("busy_done_c46", 32'(done), 1);
    step_to(50); chk("busy_done_count", 32'(done_seen - d_snap), 1);

    // Back-to-back loads, N = 6
    cfg(32'h300, 32, 0, 0, 32'h700, 64);
    d_snap = done_seen;
    go();
    step_to(9); chk("b2b_ready_c9", 32'(ready), 1);
    go();
    step_to(3); chk("b2b_rd_c3", rd_addr_global, 32'h700);
    step_to(4); chk("b2b_we_c4", 32'(we_fused), 32'h1_0000);
    step_to(5); chk("b2b_we_c5", 32'(we_fused), 32'h2_0000);
    step_to(8); chk("b2b_done_c8", 32'(done), 1);
    step_to(9); chk("b2b_done_count", 32'(done_seen - d_snap), 2);

    // Reset in the middle of W1
    cfg(32'h0, 64, 32'h1000, 512, 32'h2000, 128);
    d_snap = done_seen;
    go();
    step_to(12); reset_n = 1'b0;
    step_to(13);
    chk("abort_we", 32'(we_fused), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ready", 32'(ready), 1);
    chk("abort_rd", rd_addr_global, 0);
    chk("abort_done", 32'(done), 0);
    reset_n = 1'b1;
    step_to(60); chk("abort_no_done", 32'(done_seen - d_snap), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
